sysid_regs: RTL
===============

SYSID_REGS -- requirements
Module: sysid_regs

Interface
REQ-001 Parameters SHALL be: ID_VALUE, 32'h0000_0000, system ID constant; TIMESTAMP, 32'h0000_0000, build timestamp constant; UPTIME_W, 64, uptime counter width (33..64); SCRATCH_RST, 32'h0000_0000, scratch reset value.
REQ-002 Ports SHALL be, in order: clock  in  1  single system clock, rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 address  in  3  word address of Avalon-MM slave.
REQ-005 read  in  1  read strobe, one cycle per transfer.
REQ-006 write  in  1  write strobe, one cycle per transfer.
REQ-007 writedata  in  32  write data.
REQ-008 readdata  out  32  registered read data.
REQ-009 readdatavalid  out  1  high exactly one cycle, one cycle after read.

Function
REQ-010 Register map SHALL be: 0 ID (RO, ID_VALUE); 1 TIMESTAMP (RO); 2 UPTIME_LO (RO); 3 UPTIME_HI (RO, shadow); 4 SCRATCH (RW); 5 CAPS (RO); 6 CTRL (RW); 7 reserved (reads 0, writes ignored).
REQ-011 Read latency SHALL be fixed at 1 cycle; no waitrequest; back-to-back reads every cycle SHALL be supported.
REQ-012 readdata SHALL hold its last value while readdatavalid is low.
REQ-013 Uptime counter SHALL increment by 1 each cycle unless CTRL.freeze (bit1) is 1, and wrap from 2^UPTIME_W-1 to 0.
REQ-014 Reading UPTIME_LO SHALL return counter bits [31:0] and, same edge, latch bits [UPTIME_W-1:32] (zero-extended) into the HI shadow; UPTIME_HI SHALL return the shadow only.
REQ-015 CTRL.clear (bit0) SHALL be write-1 self-clearing: counter becomes 0 on the edge after the write, bit0 always reads 0.
REQ-016 Clear SHALL take priority over increment and freeze in the same cycle.
REQ-017 A UPTIME_LO read coinciding with a clear write SHALL return the pre-clear value.
REQ-018 CAPS SHALL read {16'h0, UPTIME_W[7:0], 7'h0, uptime_present}.
REQ-019 Writes to RO addresses SHALL be ignored; CTRL bits [31:2] SHALL read 0.
REQ-020 If read and write assert together, the write SHALL take effect and readdata SHALL return the pre-write value, with readdatavalid asserted.

Reset
REQ-021 On reset_n low, asynchronously: readdata=0, readdatavalid=0, counter=0, HI shadow=0, SCRATCH=SCRATCH_RST, CTRL=0.
REQ-022 Reset mid-read SHALL suppress the pending readdatavalid.
REQ-023 First increment SHALL occur on the first rising edge after reset_n deasserts.

Configuration
REQ-024 Macro SYSID_UPTIME_EN defined: counter, shadow and CTRL implemented, CAPS bit0=1.
REQ-025 SYSID_UPTIME_EN undefined: no counter logic; addresses 2, 3, 6 read 0, writes ignored; CAPS bit0=0; rest of map unchanged.

Structure
REQ-026 Package sysid_pkg SHALL hold address constants (ADDR_ID..ADDR_RSVD), CTRL bit indices, CAPS field layout.
REQ-027 Counter, clear/freeze logic and HI shadow SHALL be sub-module sysid_uptime_counter, instantiated only under SYSID_UPTIME_EN.

Verification
REQ-028 ID_VALUE=32'h5290_3E7B; read address 0 -> cycle+1 readdatavalid=1, readdata=32'h5290_3E7B; read address 7 -> 0.
REQ-029 Write 32'hDEAD_BEEF to 4, then read 4 -> 32'hDEAD_BEEF; reset -> read 4 returns SCRATCH_RST.
REQ-030 Force counter to 64'h0000_0001_FFFF_FFFF, read 2 -> 32'hFFFF_FFFF; next read 3 -> 32'h0000_0001 though counter has since carried.
REQ-031 Write CTRL=2'b11 (clear+freeze) -> subsequent reads of 2 return 0 repeatedly; write CTRL=0 -> value grows by cycle count between reads.
REQ-032 Counter at 2^UPTIME_W-1 (UPTIME_W=40) -> next cycle 0, read 3 after read 2 returns 0.
REQ-033 Build without SYSID_UPTIME_EN: read 2, 3, 6 -> 0; read 5 -> bit0=0; other registers as REQ-028/029.

Source files
------------

// File: rtl/sysid_pkg.sv
// sysid_pkg -- register map constants and CAPS layout shared by sysid_regs and its sub-module.
`default_nettype none

package sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
  localparam logic [2:0] ADDR_CAPS      = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam int CAPS_PRESENT_BIT = 0;
  localparam int CAPS_WIDTH_LSB   = 8;
  localparam int CAPS_WIDTH_MSB   = 15;

  function automatic logic [31:0] caps_word(input logic [7:0] width, input logic present);
    return {16'h0000, width, 7'h00, present};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter -- free-running uptime counter with clear/freeze and a HI shadow latched on LO reads.
`default_nettype none

module sysid_uptime_counter #(
  parameter int unsigned UPTIME_W = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        freeze_i,
  input  logic        latch_i,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [UPTIME_W-1:0] cnt_q, cnt_d;
  logic [31:0]         shadow_q, shadow_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_i) begin
      cnt_d = cnt_q + UPTIME_W'(1);
    end
  end

  // Shadow captures the pre-update upper bits so a LO/HI pair is coherent.
  always_comb begin
    shadow_d = shadow_q;
    if (latch_i) begin
      shadow_d = 32'(cnt_q[UPTIME_W-1:32]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign lo_o = cnt_q[31:0];
  assign hi_o = shadow_q;

endmodule

`default_nettype wire

// File: rtl/sysid_regs.sv
// sysid_regs -- Avalon-MM system ID / uptime register block, 1-cycle read latency.
// Optional uptime counter, shadow and CTRL enabled by defining SYSID_UPTIME_EN.
`default_nettype none

module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter int unsigned UPTIME_W    = 64,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [7:0] UPTIME_W8 = 8'(UPTIME_W);

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q;
  logic [31:0] rd_mux;
  logic [31:0] uptime_lo, uptime_hi, ctrl_rd;
  logic        uptime_present;

`ifdef SYSID_UPTIME_EN
  logic freeze_q, freeze_d;
  logic ctrl_wr;

  assign ctrl_wr  = write && (address == ADDR_CTRL);
  assign freeze_d = ctrl_wr ? writedata[CTRL_FREEZE_BIT] : freeze_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) freeze_q <= 1'b0;
    else          freeze_q <= freeze_d;
  end

  sysid_uptime_counter #(
    .UPTIME_W (UPTIME_W)
  ) u_uptime (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (ctrl_wr && writedata[CTRL_CLEAR_BIT]),
    .freeze_i (freeze_q),
    .latch_i  (read && (address == ADDR_UPTIME_LO)),
    .lo_o     (uptime_lo),
    .hi_o     (uptime_hi)
  );

  // Clear is self-clearing, so only the freeze bit is ever visible.
  assign ctrl_rd        = 32'(freeze_q) << CTRL_FREEZE_BIT;
  assign uptime_present = 1'b1;
`else
  assign uptime_lo      = 32'h0;
  assign uptime_hi      = 32'h0;
  assign ctrl_rd        = 32'h0;
  assign uptime_present = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'h0;
    unique case (address)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux = uptime_lo;
      ADDR_UPTIME_HI: rd_mux = uptime_hi;
      ADDR_SCRATCH:   rd_mux = scratch_q;
      ADDR_CAPS:      rd_mux = caps_word(UPTIME_W8, uptime_present);
      ADDR_CTRL:      rd_mux = ctrl_rd;
      ADDR_RSVD:      rd_mux = 32'h0;
      default:        rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    scratch_d  = scratch_q;
    readdata_d = readdata_q;
    if (write && (address == ADDR_SCRATCH)) scratch_d = writedata;
    if (read) readdata_d = rd_mux;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= SCRATCH_RST;
      readdata_q <= 32'h0;
      rdv_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      readdata_q <= readdata_d;
      rdv_q      <= read;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule

`default_nettype wire
